// File: rtl/product_accumulator_8.sv
// Accumulates a programmed-length burst of 8-bit products into one ACC_W-bit sum.
// The sum is presented on a valid/ready output and held until the consumer accepts it.
module product_accumulator_8 #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [7:0]       prod,
    output logic             busy,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [ACC_W-1:0] sum,
    output logic             sum_ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_rem;
    logic [ACC_W-1:0] r_sum;
    logic             r_sum_ovf;
    logic             r_prod_ready;
    logic             r_busy;
    logic             r_sum_valid;
    logic             w_hs;
    logic             w_last;
    logic [ACC_W:0]   w_add;

    // r_prod_ready is high exactly in ACCUM, so it doubles as the state qualifier
    assign w_hs   = prod_valid & r_prod_ready;
    assign w_last = (r_rem == CNT_W'(1));
    assign w_add  = {1'b0, r_acc} + (ACC_W+1)'(prod);

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (len != '0) ? S_ACCUM : S_DONE;
                end
            end
            S_ACCUM: begin
                if (w_hs && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (sum_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= S_IDLE;
            r_prod_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_sum_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prod_ready <= (w_state_nxt == S_ACCUM);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_sum_valid  <= (w_state_nxt == S_DONE);
        end
    end

    // Accumulator, remaining counter and result registers
    always_ff @(posedge clk) begin
        if (srst) begin
            r_acc     <= '0;
            r_rem     <= '0;
            r_sum     <= '0;
            r_sum_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sum_ovf <= 1'b0;
                        if (len != '0) begin
                            r_acc <= '0;
                            r_rem <= len;
                        end else begin
                            r_sum <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_hs) begin
                        r_acc     <= w_add[ACC_W-1:0];
                        r_sum_ovf <= r_sum_ovf | w_add[ACC_W];
                        r_rem     <= r_rem - CNT_W'(1);
                        if (w_last) begin
                            r_sum <= w_add[ACC_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign prod_ready = r_prod_ready;
    assign busy       = r_busy;
    assign sum_valid  = r_sum_valid;
    assign sum        = r_sum;
    assign sum_ovf    = r_sum_ovf;

endmodule

// File: tb/tb_product_accumulator_8.sv
// Scoreboard bench for product_accumulator_8: stimulus pushes expected sums,
// an independent monitor pops and compares each time a sum is presented.
module tb_product_accumulator_8;

    localparam int unsigned ACC_W = 10;
    localparam int unsigned CNT_W = 8;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [ACC_W-1:0] s;
        logic             o;
    } exp_t;

    logic             clk = 1'b0;
    logic             srst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             prod_valid;
    logic             prod_ready;
    logic [7:0]       prod;
    logic             busy;
    logic             sum_valid;
    logic             sum_ready;
    logic [ACC_W-1:0] sum;
    logic             sum_ovf;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    product_accumulator_8 #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .srst       (srst),
        .start      (start),
        .len        (len),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod       (prod),
        .busy       (busy),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sum        (sum),
        .sum_ovf    (sum_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: first cycle of sum_valid pops the scoreboard, later cycles check hold stability
    exp_t held;
    bit   seen = 1'b0;
    always @(negedge clk) begin
        if (!srst && sum_valid) begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sum", 32'd1, 32'd0);
                end else begin
                    held = exp_q.pop_front();
                    check("sum", 32'(sum), 32'(held.s));
                    check("sum_ovf", 32'(sum_ovf), 32'(held.o));
                end
                seen = 1'b1;
            end else begin
                check("sum_hold", 32'(sum), 32'(held.s));
                check("ovf_hold", 32'(sum_ovf), 32'(held.o));
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic send_product(input logic [7:0] p, input int gap);
        bit ok = 1'b0;
        prod_valid = 1'b1;
        prod       = p;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (prod_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("prod_ready_timeout", 32'd0, 32'd1);
        else     check("busy_accum", 32'(busy), 32'd1);
        tick();
        prod_valid = 1'b0;
        prod       = 8'(($urandom));
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("gap_ready", 32'(prod_ready), 32'd1);
            check("gap_busy", 32'(busy), 32'd1);
            tick();
        end
    endtask

    // Full burst: model the expected result arithmetically, then drive and accept it
    task automatic do_burst(input int n, input bq_t ps, input int gap, input int hold,
                            input bit start_at_accept);
        longint unsigned tot = 0;
        exp_t e;
        foreach (ps[i]) tot += longint'(ps[i]);
        e.s = ACC_W'(tot % (64'd1 << ACC_W));
        e.o = (tot >= (64'd1 << ACC_W));
        exp_q.push_back(e);
        sum_ready = 1'b0;
        start     = 1'b1;
        len       = CNT_W'(n);
        tick();
        start = 1'b0;
        len   = CNT_W'($urandom);
        for (int i = 0; i < n; i++) begin
            send_product(ps[i], (i == n - 1) ? 0 : gap);
        end
        @(negedge clk);
        check("latency_valid", 32'(sum_valid), 32'd1);
        check("done_ready", 32'(prod_ready), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            prod_valid = 1'b1;
            prod       = 8'd99;
            @(negedge clk);
            check("hold_ready", 32'(prod_ready), 32'd0);
            check("hold_valid", 32'(sum_valid), 32'd1);
        end
        tick();
        prod_valid = 1'b0;
        sum_ready  = 1'b1;
        start      = start_at_accept;
        len        = CNT_W'(5);
        tick();
        sum_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(sum_valid), 32'd0);
        tick();
        @(negedge clk);
        check("idle_busy2", 32'(busy), 32'd0);
    endtask

    initial begin
        bq_t q;
        srst       = 1'b1;
        start      = 1'b0;
        len        = '0;
        prod_valid = 1'b0;
        prod       = '0;
        sum_ready  = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_ready", 32'(prod_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(sum_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_ovf", 32'(sum_ovf), 32'd0);
        srst = 1'b0;

        q = '{8'd5, 8'd10, 8'd20};
        do_burst(3, q, 0, 0, 1'b0);
        q = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_burst(4, q, 3, 0, 1'b0);
        q = {};
        do_burst(0, q, 0, 0, 1'b0);
        q = '{8'd17, 8'd33};
        do_burst(2, q, 0, 5, 1'b1);
        q = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        do_burst(5, q, 0, 0, 1'b0);
        q = '{8'd7};
        do_burst(1, q, 0, 0, 1'b0);

        // Abandoned burst: no result is expected for it
        start = 1'b1;
        len   = CNT_W'(4);
        tick();
        start = 1'b0;
        send_product(8'd50, 0);
        send_product(8'd60, 0);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(prod_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(sum_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_ovf", 32'(sum_ovf), 32'd0);
        q = '{8'd3, 8'd4};
        do_burst(2, q, 0, 0, 1'b0);

        for (int b = 0; b < 20; b++) begin
            int n;
            n = (b == 7) ? 255 : int'($urandom_range(0, 10));
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
            do_burst(n, q, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
